// File: rtl/ibram_loader.sv
// ibram_loader
//
// Boot-time program loader placed in front of the instruction BRAM write
// port. A byte stream arrives over a valid/ready handshake with this frame
// layout: two length bytes (16-bit word count N, little-endian), then 4N data
// bytes (each word LSB first), then one checksum byte. The checksum is the
// XOR of the data bytes only. Each assembled 32-bit word is written to
// consecutive 4-byte-aligned BRAM addresses. The core's PC is held stalled
// until the whole image has loaded and its checksum matches.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   start        : one-cycle pulse that begins a load (ignored while busy)
//   s_dat        : stream byte
//   s_valid      : s_dat is valid
//   s_ready      : loader accepts a byte this cycle
//   w_addr       : BRAM write byte address
//   w_dat        : BRAM write data
//   w_enb        : BRAM write enable, one cycle per word
//   cpu_stall    : PC stall, released only after a verified load
//   busy         : load in progress
//   done         : image loaded and checksum matched
//   err          : load aborted (oversize length or bad checksum)
//   words_loaded : words written during the current load

module ibram_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            s_dat,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [31:0]           w_dat,
   output logic                  w_enb,
   output logic                  cpu_stall,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           words_loaded
);

   // BRAM capacity in words, kept one bit wider than the length field so
   // the oversize test never wraps.
   localparam logic [16:0] MaxWords = 17'(2 ** (ADDR_WIDTH - 2));

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_e;

   state_e                state_q, state_d;
   logic [7:0]            lenLo_q;
   logic [15:0]           len_q;
   logic [1:0]            byteIdx_q;
   logic [15:0]           wordIdx_q;
   logic [15:0]           wordsLoaded_q;
   logic [31:0]           wDat_q;
   logic [ADDR_WIDTH-1:0] wAddr_q;
   logic [7:0]            csum_q;

   logic                  accept;
   logic [15:0]           lenFull;

   // A byte moves only when the upstream offers it and the current state
   // is willing; s_ready itself depends on the state register alone.
   assign accept  = s_valid & s_ready;
   assign lenFull = {s_dat, lenLo_q};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. The length decision is taken while the high length
   // byte is on the bus, so an oversize image never enters the data phase.
   // In S_WRITE the word index has already been advanced, so it equals the
   // number of words written so far.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (accept) state_d = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (accept) begin
               if (lenFull == 16'd0)                 state_d = S_CSUM;
               else if ({1'b0, lenFull} > MaxWords)  state_d = S_ERR;
               else                                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && byteIdx_q == 2'd3) state_d = S_WRITE;
         end
         S_WRITE: begin
            state_d = (wordIdx_q < len_q) ? S_DATA : S_CSUM;
         end
         S_CSUM: begin
            if (accept) state_d = (s_dat == csum_q) ? S_DONE : S_ERR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode, driven from the state register only.
   always_comb begin
      s_ready   = 1'b0;
      w_enb     = 1'b0;
      busy      = 1'b1;
      cpu_stall = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         S_IDLE:   busy = 1'b0;
         S_LEN_LO: s_ready = 1'b1;
         S_LEN_HI: s_ready = 1'b1;
         S_DATA:   s_ready = 1'b1;
         S_WRITE:  w_enb = 1'b1;
         S_CSUM:   s_ready = 1'b1;
         S_DONE: begin
            busy      = 1'b0;
            cpu_stall = 1'b0;
            done      = 1'b1;
         end
         S_ERR: begin
            busy = 1'b0;
            err  = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   // Datapath. The write address, data and word counters are all updated
   // on the edge that accepts the fourth byte of a word, so they are stable
   // throughout the single write cycle and words_loaded steps together with
   // w_enb. The address uses the word index before it advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         lenLo_q       <= '0;
         len_q         <= '0;
         byteIdx_q     <= '0;
         wordIdx_q     <= '0;
         wordsLoaded_q <= '0;
         wDat_q        <= '0;
         wAddr_q       <= '0;
         csum_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  byteIdx_q     <= '0;
                  wordIdx_q     <= '0;
                  wordsLoaded_q <= '0;
                  csum_q        <= '0;
               end
            end
            S_LEN_LO: begin
               if (accept) lenLo_q <= s_dat;
            end
            S_LEN_HI: begin
               if (accept) len_q <= lenFull;
            end
            S_DATA: begin
               if (accept) begin
                  wDat_q[{byteIdx_q, 3'b000} +: 8] <= s_dat;
                  csum_q    <= csum_q ^ s_dat;
                  byteIdx_q <= byteIdx_q + 2'd1;
                  if (byteIdx_q == 2'd3) begin
                     wAddr_q       <= {wordIdx_q[ADDR_WIDTH-3:0], 2'b00};
                     wordIdx_q     <= wordIdx_q + 16'd1;
                     wordsLoaded_q <= wordsLoaded_q + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign w_addr       = wAddr_q;
   assign w_dat        = wDat_q;
   assign words_loaded = wordsLoaded_q;

endmodule

// File: tb/tb_ibram_loader.sv
// Testbench for ibram_loader: drives framed byte streams, keeps a scoreboard
// of expected BRAM writes that a negedge monitor pops on every w_enb, and
// checks status outputs after each frame.

module tb_ibram_loader;

   localparam int AW = 10;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [15:0]   count;
   } expWrite_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [7:0]    s_dat;
   logic          s_valid;
   logic          s_ready;
   logic [AW-1:0] w_addr;
   logic [31:0]   w_dat;
   logic          w_enb;
   logic          cpu_stall;
   logic          busy;
   logic          done;
   logic          err;
   logic [15:0]   words_loaded;

   ibram_loader #(.ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .s_dat        (s_dat),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .w_addr       (w_addr),
      .w_dat        (w_dat),
      .w_enb        (w_enb),
      .cpu_stall    (cpu_stall),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   int            totalChecks = 0;
   int            badChecks   = 0;
   int            writeCount  = 0;
   int            cycleCount  = 0;
   int            byteNo      = 0;
   int            startPulseAt = -1;
   bit            gapMode     = 1'b0;
   logic          prevEnb     = 1'b0;
   logic [AW-1:0] lastAddr    = '0;
   expWrite_t     sb[$];
   logic [31:0]   frameWords[$];
   logic [31:0]   bram[256];

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Simple BRAM model so loaded words can be fetched back in order.
   always @(posedge clk) begin
      if (w_enb) bram[w_addr[AW-1:2]] <= w_dat;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Write monitor: every w_enb pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && w_enb) begin
         writeCount++;
         lastAddr = w_addr;
         checkOutput("wrPulse", 64'(prevEnb), 64'(0));
         checkOutput("wrReady", 64'(s_ready), 64'(0));
         if (sb.size() == 0) begin
            checkOutput("wrUnexpected", 64'(1), 64'(0));
         end else begin
            expWrite_t e;
            e = sb.pop_front();
            checkOutput("wrAddr", 64'(w_addr), 64'(e.addr));
            checkOutput("wrData", 64'(w_dat), 64'(e.data));
            checkOutput("wrCount", 64'(words_loaded), 64'(e.count));
         end
      end
      prevEnb = w_enb;
   end

   // Offer one byte (entered and left at a negedge) and hold it until taken.
   task automatic sendByte(input logic [7:0] b);
      int guard;
      guard = 0;
      if (gapMode && $urandom_range(0, 2) == 0) begin
         s_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      s_dat   = b;
      s_valid = 1'b1;
      while (!s_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!s_ready) checkOutput("readyTimeout", 64'(0), 64'(1));
      if (byteNo == startPulseAt) start = 1'b1;
      @(posedge clk);
      start = 1'b0;
      byteNo++;
      @(negedge clk);
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      checkOutput("startReady", 64'(s_ready), 64'(1));
      checkOutput("startBusy", 64'(busy), 64'(1));
      checkOutput("startStall", 64'(cpu_stall), 64'(1));
      checkOutput("startDone", 64'(done), 64'(0));
      checkOutput("startErr", 64'(err), 64'(0));
      checkOutput("startWords", 64'(words_loaded), 64'(0));
   endtask

   // Stream frameWords as a full frame; stopAfter >= 0 stops after that many
   // data bytes. Expected writes are queued as their last byte is driven.
   task automatic applyStimulus(input bit badCsum, input int stopAfter);
      logic [15:0] nLen;
      logic [31:0] w;
      logic [7:0]  b;
      logic [7:0]  cs;
      int          sent;
      expWrite_t   e;
      nLen = 16'(frameWords.size());
      cs   = 8'h00;
      sent = 0;
      byteNo = 0;
      sendByte(nLen[7:0]);
      sendByte(nLen[15:8]);
      for (int i = 0; i < frameWords.size(); i++) begin
         w = frameWords[i];
         for (int k = 0; k < 4; k++) begin
            if (sent == stopAfter) begin
               s_valid = 1'b0;
               return;
            end
            b  = w[8*k +: 8];
            cs = cs ^ b;
            if (k == 3) begin
               e.addr  = AW'(i * 4);
               e.data  = w;
               e.count = 16'(i + 1);
               sb.push_back(e);
            end
            sendByte(b);
            sent++;
         end
      end
      sendByte(badCsum ? (cs ^ 8'h01) : cs);
      s_valid = 1'b0;
   endtask

   task automatic checkStatus(input logic expDone, input logic expErr, input int expWords);
      #1;
      checkOutput("done", 64'(done), 64'(expDone));
      checkOutput("err", 64'(err), 64'(expErr));
      checkOutput("stall", 64'(cpu_stall), 64'(!expDone));
      checkOutput("busy", 64'(busy), 64'(0));
      checkOutput("ready", 64'(s_ready), 64'(0));
      checkOutput("wordsLoaded", 64'(words_loaded), 64'(expWords));
      checkOutput("sbEmpty", 64'(sb.size()), 64'(0));
   endtask

   task automatic checkResetValues();
      #1;
      checkOutput("rstReady", 64'(s_ready), 64'(0));
      checkOutput("rstEnb", 64'(w_enb), 64'(0));
      checkOutput("rstAddr", 64'(w_addr), 64'(0));
      checkOutput("rstDat", 64'(w_dat), 64'(0));
      checkOutput("rstStall", 64'(cpu_stall), 64'(1));
      checkOutput("rstBusy", 64'(busy), 64'(0));
      checkOutput("rstDone", 64'(done), 64'(0));
      checkOutput("rstErr", 64'(err), 64'(0));
      checkOutput("rstWords", 64'(words_loaded), 64'(0));
   endtask

   task automatic loadNominal();
      frameWords = '{32'h00500093, 32'h00300113, 32'h002081b3, 32'h00000013};
   endtask

   initial begin
      int c0;
      int w0;
      rst     = 1'b1;
      start   = 1'b0;
      s_dat   = 8'h00;
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkResetValues();
      @(negedge clk);
      rst = 1'b0;

      // Nominal load with s_valid held: 4 bytes per 5 cycles.
      $display("[TB] nominal load");
      loadNominal();
      pulseStart();
      c0 = cycleCount;
      w0 = writeCount;
      applyStimulus(1'b0, -1);
      checkOutput("throughput", 64'(cycleCount - c0), 64'(3 + 5 * 4));
      checkStatus(1'b1, 1'b0, 4);
      checkOutput("nomWrites", 64'(writeCount - w0), 64'(4));
      for (int i = 0; i < 4; i++) checkOutput("fetch", 64'(bram[i]), 64'(frameWords[i]));

      // Bad checksum: all writes happen, then err with the core still stalled.
      $display("[TB] bad checksum");
      pulseStart();
      w0 = writeCount;
      applyStimulus(1'b1, -1);
      checkStatus(1'b0, 1'b1, 4);
      checkOutput("badWrites", 64'(writeCount - w0), 64'(4));

      // Random gaps plus a start pulse mid-frame that must be ignored.
      $display("[TB] gaps and stray start");
      gapMode = 1'b1;
      startPulseAt = 7;
      pulseStart();
      w0 = writeCount;
      applyStimulus(1'b0, -1);
      gapMode = 1'b0;
      startPulseAt = -1;
      checkStatus(1'b1, 1'b0, 4);
      checkOutput("gapWrites", 64'(writeCount - w0), 64'(4));

      // Empty image.
      $display("[TB] N=0");
      frameWords.delete();
      pulseStart();
      w0 = writeCount;
      applyStimulus(1'b0, -1);
      checkStatus(1'b1, 1'b0, 0);
      checkOutput("n0Writes", 64'(writeCount - w0), 64'(0));

      // Oversize image rejected right after the length.
      $display("[TB] N=257");
      pulseStart();
      w0 = writeCount;
      sendByte(8'h01);
      sendByte(8'h01);
      s_valid = 1'b0;
      checkStatus(1'b0, 1'b1, 0);
      repeat (3) @(negedge clk);
      checkStatus(1'b0, 1'b1, 0);
      checkOutput("n257Writes", 64'(writeCount - w0), 64'(0));

      // Full-capacity image.
      $display("[TB] N=256");
      frameWords.delete();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] iv;
         iv = 8'(i);
         frameWords.push_back({iv ^ 8'h5A, iv, 8'hC3, ~iv});
      end
      pulseStart();
      w0 = writeCount;
      applyStimulus(1'b0, -1);
      checkStatus(1'b1, 1'b0, 256);
      checkOutput("n256Writes", 64'(writeCount - w0), 64'(256));
      checkOutput("n256LastAddr", 64'(lastAddr), 64'(10'h3FC));

      // Reset after 6 data bytes, then a clean reload.
      $display("[TB] reset mid-load");
      loadNominal();
      pulseStart();
      applyStimulus(1'b0, 6);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkResetValues();
      checkOutput("rstSbEmpty", 64'(sb.size()), 64'(0));
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      pulseStart();
      applyStimulus(1'b0, -1);
      checkStatus(1'b1, 1'b0, 4);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   // Global watchdog so the bench always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
